// File: rtl/safecrack_supervisor_if.sv
// Button, checker and status signals that pass between the board/checker side and the safecrack supervisor.
interface safecrack_supervisor_if #(
    parameter int MAX_FAILS = 3
);
    localparam int FCW = $clog2(MAX_FAILS + 1);

    logic [2:0]     btn_i;
    logic           prog_sw_i;
    logic           chk_fail_i;
    logic           chk_unlocked_i;
    logic [2:0]     btn_fwd_o;
    logic [5:0]     code_o;
    logic           lockout_o;
    logic           prog_active_o;
    logic [1:0]     prog_idx_o;
    logic           prog_done_o;
    logic [FCW-1:0] fail_cnt_o;

    modport master (
        output btn_i, prog_sw_i, chk_fail_i, chk_unlocked_i,
        input  btn_fwd_o, code_o, lockout_o, prog_active_o, prog_idx_o, prog_done_o, fail_cnt_o
    );

    modport slave (
        input  btn_i, prog_sw_i, chk_fail_i, chk_unlocked_i,
        output btn_fwd_o, code_o, lockout_o, prog_active_o, prog_idx_o, prog_done_o, fail_cnt_o
    );
endinterface

// File: rtl/safecrack_supervisor.sv
// Supervisor in front of the safecrack checker: owns the combination, gates buttons,
// counts failed attempts into a timed lockout, and runs owner-only reprogramming.
module safecrack_supervisor #(
    parameter int         MAX_FAILS      = 3,
    parameter int         LOCKOUT_CYCLES = 500_000_000,
    parameter int         PROG_TIMEOUT   = 500_000_000,
    parameter logic [5:0] DEFAULT_CODE   = 6'b10_01_00
) (
    input logic                   clk,
    input logic                   rstn,
    safecrack_supervisor_if.slave bus
);
    localparam int FCW  = $clog2(MAX_FAILS + 1);
    localparam int TMAX = (LOCKOUT_CYCLES > PROG_TIMEOUT) ? LOCKOUT_CYCLES : PROG_TIMEOUT;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0]  LOCK_LOAD = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [TW-1:0]  PROG_LOAD = TW'(PROG_TIMEOUT - 1);
    localparam logic [FCW-1:0] FAIL_MAX  = FCW'(MAX_FAILS);
    localparam logic [FCW-1:0] FAIL_LAST = FCW'(MAX_FAILS - 1);

    typedef enum logic [1:0] {
        ST_NORMAL,
        ST_PROG,
        ST_LOCKOUT
    } state_t;

    state_t         state_q, state_d;
    logic [5:0]     code_q, code_d;
    logic [3:0]     shadow_q, shadow_d;
    logic [FCW-1:0] fail_cnt_q, fail_cnt_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [1:0]     prog_idx_q, prog_idx_d;
    logic           prog_done_q, prog_done_d;
    logic [2:0]     btn_prev_q;
    logic           prog_sw_prev_q;

    logic [2:0] btn_pos;
    logic [2:0] btn_edge;
    logic       single_press;
    logic [1:0] press_val;
    logic       psw_rise;
    logic       prog_abort;

    always_comb begin
        btn_pos      = ~bus.btn_i;
        btn_edge     = btn_pos & ~btn_prev_q;
        single_press = 1'b1;
        press_val    = 2'd0;
        case (btn_edge)
            3'b001:  press_val = 2'd0;
            3'b010:  press_val = 2'd1;
            3'b100:  press_val = 2'd2;
            default: single_press = 1'b0;
        endcase
    end

    assign psw_rise   = bus.prog_sw_i & ~prog_sw_prev_q;
    // Unlock level can only drop while in PROG, since entry requires it high.
    assign prog_abort = ~bus.prog_sw_i | ~bus.chk_unlocked_i;

    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        shadow_d    = shadow_q;
        fail_cnt_d  = fail_cnt_q;
        timer_d     = timer_q;
        prog_idx_d  = prog_idx_q;
        prog_done_d = 1'b0;
        case (state_q)
            ST_NORMAL: begin
                if (bus.chk_fail_i) begin
                    if (fail_cnt_q == FAIL_LAST) begin
                        state_d    = ST_LOCKOUT;
                        timer_d    = LOCK_LOAD;
                        fail_cnt_d = FAIL_MAX;
                    end else begin
                        fail_cnt_d = fail_cnt_q + FCW'(1);
                    end
                end else if (bus.chk_unlocked_i) begin
                    fail_cnt_d = '0;
                    if (psw_rise) begin
                        state_d    = ST_PROG;
                        prog_idx_d = 2'd0;
                        timer_d    = PROG_LOAD;
                    end
                end
            end
            ST_LOCKOUT: begin
                if (timer_q == '0) begin
                    state_d    = ST_NORMAL;
                    fail_cnt_d = '0;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_PROG: begin
                if (prog_abort) begin
                    state_d    = ST_NORMAL;
                    prog_idx_d = 2'd0;
                end else if (single_press) begin
                    if (prog_idx_q == 2'd2) begin
                        code_d      = {press_val, shadow_q};
                        prog_done_d = 1'b1;
                        fail_cnt_d  = '0;
                        prog_idx_d  = 2'd0;
                        state_d     = ST_NORMAL;
                    end else begin
                        if (prog_idx_q == 2'd0) begin
                            shadow_d[1:0] = press_val;
                        end else begin
                            shadow_d[3:2] = press_val;
                        end
                        prog_idx_d = prog_idx_q + 2'd1;
                        timer_d    = PROG_LOAD;
                    end
                end else if (timer_q == '0) begin
                    state_d    = ST_NORMAL;
                    prog_idx_d = 2'd0;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: state_d = ST_NORMAL;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= ST_NORMAL;
            code_q         <= DEFAULT_CODE;
            shadow_q       <= '0;
            fail_cnt_q     <= '0;
            timer_q        <= '0;
            prog_idx_q     <= 2'd0;
            prog_done_q    <= 1'b0;
            btn_prev_q     <= 3'b000;
            prog_sw_prev_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            code_q         <= code_d;
            shadow_q       <= shadow_d;
            fail_cnt_q     <= fail_cnt_d;
            timer_q        <= timer_d;
            prog_idx_q     <= prog_idx_d;
            prog_done_q    <= prog_done_d;
            btn_prev_q     <= btn_pos;
            prog_sw_prev_q <= bus.prog_sw_i;
        end
    end

    assign bus.btn_fwd_o     = (state_q == ST_NORMAL) ? bus.btn_i : 3'b111;
    assign bus.code_o        = code_q;
    assign bus.lockout_o     = (state_q == ST_LOCKOUT);
    assign bus.prog_active_o = (state_q == ST_PROG);
    assign bus.prog_idx_o    = prog_idx_q;
    assign bus.prog_done_o   = prog_done_q;
    assign bus.fail_cnt_o    = fail_cnt_q;
endmodule

// File: tb/tb_safecrack_supervisor.sv
// Directed bench for safecrack_supervisor: a vector table for the single-cycle behaviour
// plus hand sequences for lockout length, programming timeout and asynchronous reset.
module tb_safecrack_supervisor;
    logic clk;
    logic rstn;
    int   total;
    int   bad;

    safecrack_supervisor_if #(.MAX_FAILS(3)) bus ();

    safecrack_supervisor #(
        .MAX_FAILS(3),
        .LOCKOUT_CYCLES(20),
        .PROG_TIMEOUT(50),
        .DEFAULT_CODE(6'b10_01_00)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] btn;
        logic       psw;
        logic       fail;
        logic       unl;
        logic [1:0] fc;
        logic       lo;
        logic       pa;
        logic [1:0] idx;
        logic       pd;
        logic [5:0] code;
        logic [2:0] fwd;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [2:0] b, input logic s, input logic f, input logic u,
                       input logic [1:0] fc, input logic lo, input logic pa, input logic [1:0] idx,
                       input logic pd, input logic [5:0] code, input logic [2:0] fwd);
        vec_t v;
        v.btn = b; v.psw = s; v.fail = f; v.unl = u;
        v.fc = fc; v.lo = lo; v.pa = pa; v.idx = idx; v.pd = pd; v.code = code; v.fwd = fwd;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] b, input logic s, input logic f, input logic u);
        bus.btn_i          = b;
        bus.prog_sw_i      = s;
        bus.chk_fail_i     = f;
        bus.chk_unlocked_i = u;
    endtask

    task automatic fail_pulse();
        bus.chk_fail_i = 1'b1;
        tick();
        bus.chk_fail_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        int gate_bad;
        int waited;
        total = 0;
        bad   = 0;

        //   btn     psw   fail  unl   fc    lo    pa    idx   pd    code      fwd
        add(3'b111, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 6'h24, 3'b111);
        add(3'b111, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 2'd0, 1'b0, 6'h24, 3'b111);
        add(3'b110, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 2'd0, 1'b0, 6'h24, 3'b110);
        add(3'b111, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 2'd0, 1'b0, 6'h24, 3'b111);
        add(3'b111, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 6'h24, 3'b111);
        add(3'b111, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 2'd0, 1'b0, 6'h24, 3'b111);
        add(3'b011, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 2'd1, 1'b0, 6'h24, 3'b111);
        add(3'b111, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 2'd1, 1'b0, 6'h24, 3'b111);
        add(3'b110, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 2'd2, 1'b0, 6'h24, 3'b111);
        add(3'b111, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 2'd2, 1'b0, 6'h24, 3'b111);
        add(3'b101, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1, 6'h12, 3'b101);
        add(3'b111, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 6'h12, 3'b111);
        add(3'b111, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 6'h12, 3'b111);
        add(3'b111, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 6'h12, 3'b111);
        add(3'b111, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 6'h12, 3'b111);
        add(3'b111, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 6'h12, 3'b111);
        add(3'b111, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 2'd0, 1'b0, 6'h12, 3'b111);
        add(3'b100, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 2'd0, 1'b0, 6'h12, 3'b111);
        add(3'b111, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 2'd0, 1'b0, 6'h12, 3'b111);
        add(3'b110, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 2'd1, 1'b0, 6'h12, 3'b111);
        add(3'b111, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 6'h12, 3'b111);
        add(3'b111, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 2'd0, 1'b0, 6'h12, 3'b111);
        add(3'b111, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 6'h12, 3'b111);

        rstn = 1'b0;
        drive(3'b110, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        #1;
        check("rst_code", bus.code_o, 6'h24);
        check("rst_fc", bus.fail_cnt_o, 0);
        check("rst_lo", bus.lockout_o, 0);
        check("rst_pa", bus.prog_active_o, 0);
        check("rst_idx", bus.prog_idx_o, 0);
        check("rst_pd", bus.prog_done_o, 0);
        check("rst_fwd", bus.btn_fwd_o, 3'b110);
        drive(3'b111, 1'b0, 1'b0, 1'b0);
        tick();

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].btn, vq[i].psw, vq[i].fail, vq[i].unl);
            tick();
            check($sformatf("v%0d_fc", i), bus.fail_cnt_o, vq[i].fc);
            check($sformatf("v%0d_lo", i), bus.lockout_o, vq[i].lo);
            check($sformatf("v%0d_pa", i), bus.prog_active_o, vq[i].pa);
            check($sformatf("v%0d_idx", i), bus.prog_idx_o, vq[i].idx);
            check($sformatf("v%0d_pd", i), bus.prog_done_o, vq[i].pd);
            check($sformatf("v%0d_code", i), bus.code_o, vq[i].code);
            check($sformatf("v%0d_fwd", i), bus.btn_fwd_o, vq[i].fwd);
        end

        // Programming timeout: one press reloads the timer, then 50 idle cycles abort.
        drive(3'b111, 1'b0, 1'b0, 1'b1);
        tick();
        bus.prog_sw_i = 1'b1;
        tick();
        check("to_enter", bus.prog_active_o, 1);
        bus.btn_i = 3'b011;
        tick();
        check("to_idx1", bus.prog_idx_o, 1);
        bus.btn_i = 3'b000;
        repeat (49) tick();
        check("to_still_pa", bus.prog_active_o, 1);
        check("to_still_idx", bus.prog_idx_o, 1);
        tick();
        check("to_abort_pa", bus.prog_active_o, 0);
        check("to_abort_idx", bus.prog_idx_o, 0);
        check("to_code", bus.code_o, 6'h12);
        drive(3'b111, 1'b0, 1'b0, 1'b0);
        tick();

        // Lockout after three failures, exactly 20 cycles, gated buttons, extra fail ignored.
        fail_pulse();
        check("lk_fc1", bus.fail_cnt_o, 1);
        repeat (9) tick();
        fail_pulse();
        check("lk_fc2", bus.fail_cnt_o, 2);
        repeat (9) tick();
        bus.btn_i = 3'b110;
        fail_pulse();
        check("lk_on", bus.lockout_o, 1);
        check("lk_fc3", bus.fail_cnt_o, 3);
        check("lk_fwd", bus.btn_fwd_o, 3'b111);
        cnt = 1;
        gate_bad = 0;
        for (int k = 0; k < 40; k++) begin
            bus.chk_fail_i = (k == 5);
            tick();
            if (!bus.lockout_o) break;
            cnt++;
            if (bus.btn_fwd_o !== 3'b111 || bus.fail_cnt_o !== 2'd3) gate_bad++;
        end
        bus.chk_fail_i = 1'b0;
        check("lk_len", cnt, 20);
        check("lk_gated", gate_bad, 0);
        check("lk_fc_after", bus.fail_cnt_o, 0);
        check("lk_fwd_after", bus.btn_fwd_o, 3'b110);
        tick();
        check("lk_stays_off", bus.lockout_o, 0);
        bus.btn_i = 3'b111;

        // Fail and unlock together at fail_cnt==2: fail wins.
        fail_pulse();
        fail_pulse();
        check("cl_fc2", bus.fail_cnt_o, 2);
        drive(3'b111, 1'b0, 1'b1, 1'b1);
        tick();
        check("cl_lo", bus.lockout_o, 1);
        check("cl_fc3", bus.fail_cnt_o, 3);
        drive(3'b111, 1'b0, 1'b0, 1'b0);
        waited = 0;
        while (bus.lockout_o && waited < 40) begin
            tick();
            waited++;
        end
        check("cl_exit", bus.lockout_o, 0);
        check("cl_fc0", bus.fail_cnt_o, 0);

        // Asynchronous reset mid-PROG reverts a programmed combination.
        drive(3'b111, 1'b0, 1'b0, 1'b1);
        tick();
        check("rs_code_prog", bus.code_o, 6'h12);
        bus.prog_sw_i = 1'b1;
        tick();
        bus.btn_i = 3'b011;
        tick();
        bus.btn_i = 3'b111;
        check("rs_in_prog", bus.prog_idx_o, 1);
        #2;
        rstn = 1'b0;
        #1;
        check("rs_code", bus.code_o, 6'h24);
        check("rs_pa", bus.prog_active_o, 0);
        check("rs_idx", bus.prog_idx_o, 0);
        tick();
        rstn = 1'b1;
        drive(3'b111, 1'b0, 1'b0, 1'b0);
        tick();
        check("rs_post_code", bus.code_o, 6'h24);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/safecrack_supervisor.md
Name: safecrack_supervisor

Overview:
- Supervisory controller that sits between the board push-buttons and the safecrack checker FSM.
- Owns the 3-digit combination register and drives it to the checker as configuration.
- Gates button traffic into the checker, and counts failed attempts to impose a timed lockout.
- Provides an owner-only programming mode, entered only while the safe is unlocked, for changing the combination.

Parameters:
- MAX_FAILS, 3: consecutive failed attempts that trigger lockout (≥1).
- LOCKOUT_CYCLES, 500_000_000: lockout duration in clk cycles (10 s at 50 MHz, ≥1).
- PROG_TIMEOUT, 500_000_000: idle cycles allowed in programming mode before abort (≥1).
- DEFAULT_CODE, 6'b10_01_00: reset combination; digit k = DEFAULT_CODE[2k+1:2k], value = button index 0..2.

Ports:
- clk, input, 1: system clock, 50 MHz.
- rstn, input, 1: asynchronous active-low reset.
- btn, input, 3: raw push-buttons, active-low, already synchronous to clk.
- prog_sw, input, 1: programming-request switch, level, active-high, synchronous.
- chk_fail, input, 1: one-cycle pulse from the checker on a wrong digit.
- chk_unlocked, input, 1: checker level, high while the safe is open.
- btn_fwd, output, 3: buttons forwarded to the checker, active-low; 3'b111 when gated.
- code, output, 6: current combination, digit0 in [1:0].
- lockout, output, 1: high during lockout.
- prog_active, output, 1: high in programming mode.
- prog_idx, output, 2: next digit index being programmed (0..2); 0 outside PROG.
- prog_done, output, 1: one-cycle pulse on successful commit.
- fail_cnt, output, $clog2(MAX_FAILS+1): consecutive-failure count.

Behaviour:
- Reset (rstn low, async):
  - State NORMAL; code=DEFAULT_CODE; fail_cnt=0; lockout=0; prog_active=0; prog_idx=0; prog_done=0.
  - Internal timer=0, shadow=0, btn_prev=3'b000.
- Button edges:
  - btn_pos=~btn; edge=btn_pos & ~btn_prev; btn_prev<=btn_pos every cycle in all states.
  - A "single press" is an edge vector with exactly one bit set.
- btn_fwd:
  - Combinational: btn in NORMAL, 3'b111 in PROG and LOCKOUT.
  - The checker therefore sees no edges while gated.
- State NORMAL:
  - chk_fail pulse: if fail_cnt==MAX_FAILS-1, go LOCKOUT, timer<=LOCKOUT_CYCLES-1, fail_cnt<=MAX_FAILS. Else fail_cnt+1.
  - chk_unlocked high: fail_cnt<=0.
  - chk_fail and chk_unlocked high in the same cycle: chk_fail wins.
  - prog_sw rising edge (registered prev) while chk_unlocked=1 and no chk_fail that cycle: go PROG, prog_idx<=0, timer<=PROG_TIMEOUT-1.
  - prog_sw rising edge with chk_unlocked=0: ignored; a new rising edge is required to enter PROG.
- State LOCKOUT:
  - lockout=1 for exactly LOCKOUT_CYCLES cycles; timer decrements each cycle.
  - On the cycle timer==0: go NORMAL, fail_cnt<=0.
  - chk_fail, prog_sw and buttons are ignored.
- State PROG:
  - prog_active=1.
  - Single press with index v≤2: shadow[2*prog_idx+:2]<=v, prog_idx+1, timer reloads PROG_TIMEOUT-1.
  - Multi-bit edge: ignored, timer keeps counting.
  - Single press at prog_idx==2: code<={v,shadow[3:0]}, prog_done=1 next cycle for one cycle, fail_cnt<=0, prog_idx<=0, go NORMAL.
  - Abort leaves code unchanged, prog_idx<=0, go NORMAL. Abort occurs when:
    - prog_sw is low, or
    - timer reaches 0 with no press, or
    - chk_unlocked falls.
  - Abort has priority over a press in the same cycle.
- Timing:
  - Transitions take effect the cycle after the triggering input.
  - code updates the cycle after the third press; outputs other than btn_fwd are registered.
- Reset mid-PROG or mid-LOCKOUT: immediate return to reset values; a programmed code is lost and reverts to DEFAULT_CODE.
- Counters never wrap. fail_cnt saturates at MAX_FAILS (only in LOCKOUT). The timer is sized $clog2(max(LOCKOUT_CYCLES,PROG_TIMEOUT)).

Test Plan (sim params MAX_FAILS=3, LOCKOUT_CYCLES=20, PROG_TIMEOUT=50):
- Reset release → code=6'b10_01_00, btn_fwd=btn, fail_cnt=0, all flags 0.
- Three chk_fail pulses 10 cycles apart → fail_cnt 1,2, then lockout=1 for exactly 20 cycles. btn_fwd=3'b111 throughout; a 4th chk_fail during lockout has no effect. Afterwards fail_cnt=0.
- Two chk_fail, then chk_unlocked=1 → fail_cnt=0. Assert chk_fail and chk_unlocked together at fail_cnt=2 → lockout entered.
- chk_unlocked=1, prog_sw 0→1, press btn2, btn0, btn1 (active-low pulses) → prog_idx 0→1→2, prog_done single pulse, code=6'b01_00_10, btn_fwd gated during PROG.
- In PROG after one press, hold all buttons 50 cycles → abort at timeout, code unchanged, prog_active=0. Repeat with a prog_sw drop, and with an additional btn0+btn1 simultaneous edge → ignored (prog_idx unchanged).
- prog_sw rising with chk_unlocked=0 → stays NORMAL. Assert rstn low mid-PROG after a successful commit → code returns to 6'b10_01_00 asynchronously.
